inst_fetch_responder: RTL
=========================

// Module: inst_fetch_responder
// PURPOSE
//  Instruction-memory responder at the far end of the PC fetch interface. It accepts the fetch address
//  from the PC stage and returns the instruction word after LATENCY clocks. While a fetch is
//  outstanding it drives stall_o back to the PC. Pipeline flushes (taken branch/jump) abort the
//  in-flight fetch.
// PARAMETERS
//  DEPTH_WORDS  256  instruction words stored; power of two, >=2
//  LATENCY      2    clocks from accepting edge to response edge; legal range 1..15
//  NOP_WORD     32'h00000013  word returned on error (addi x0,x0,0)
// PORTS
//  clk_i        in   1   clock, rising edge
//  rst_i        in   1   asynchronous, active-low reset
//  start_i      in   1   CPU run enable; no new fetch is accepted while low
//  req_i        in   1   fetch request; addr_i is valid
//  addr_i       in   32  byte address of the fetch (PC value)
//  flush_i      in   1   abort the outstanding fetch (branch/jump resolved)
//  load_we_i    in   1   testbench/boot write enable into instruction store
//  load_addr_i  in   $clog2(DEPTH_WORDS)  word index for the load write
//  load_data_i  in   32  word to store
//  inst_o       out  32  fetched instruction; registered
//  inst_pc_o    out  32  address that produced inst_o; registered
//  valid_o      out  1   one-cycle pulse: inst_o/inst_pc_o are new
//  err_o        out  1   one-cycle pulse with valid_o: misaligned or out-of-range fetch
//  stall_o      out  1   combinational; PC must hold while high
// BEHAVIOUR
//  Reset (rst_i=0, async): state=IDLE, cnt=0, inst_o=0, inst_pc_o=0, valid_o=0, err_o=0.
//   The instruction store is NOT cleared.
//  States: IDLE, BUSY. cnt is a 4-bit down-counter.
//  IDLE: accept = start_i & req_i & ~flush_i. On the accepting edge, latch addr_q<=addr_i,
//   cnt<=LATENCY-1, and go to BUSY.
//  BUSY, cnt!=0: cnt<=cnt-1 each edge. start_i going low does not pause the fetch.
//  BUSY, cnt==0, ~flush_i: respond on this edge and return to IDLE:
//   - inst_o <= mem[addr_q word index] and inst_pc_o <= addr_q.
//   - valid_o <= 1 for exactly one cycle.
//  Word index = addr_q[$clog2(DEPTH_WORDS)+1:2].
//  Error: if addr_q[1:0]!=0, or any addr_q bit above the index is set:
//   inst_o<=NOP_WORD and err_o<=1 together with valid_o.
//  flush_i in BUSY: on the next edge go to IDLE and drop the response (valid_o stays 0).
//   The flush-edge cycle never accepts a new request.
//  stall_o = ~flush_i & ((IDLE & start_i & req_i) | (BUSY & cnt!=0)).
//   stall_o is low in the response cycle, so the PC advances on the same edge valid_o rises.
//   The next fetch starts one cycle later.
//   Steady state: one instruction every LATENCY+1 clocks.
//  Load port: mem[load_addr_i]<=load_data_i on any edge with load_we_i=1, in any state.
//   If the load hits the word being read on the response edge, the old word is returned
//   (read-before-write).
//  Reset asserted mid-fetch: the fetch is discarded and no valid_o is produced after release.
// STRUCTURE
//  Shared package fetch_pkg holds:
//   - the state enum {IDLE, BUSY};
//   - the NOP_WORD constant (32'h00000013).
//  One sub-module, imem_array: a DEPTH_WORDS x 32 synchronous store with
//   - one write port (load);
//   - one read port with read-before-write.
//  The FSM, counter, error check and output registers stay in this module.
// TESTING
//  1 Reset: assert rst_i mid-BUSY -> valid_o=0, inst_o=0, stall_o=0 immediately; no response after release.
//  2 Basic fetch, LATENCY=2: load mem[1]=32'h00500093, then req addr 0x4 ->
//    - stall_o=1 for 2 cycles, then 0;
//    - valid_o pulses 3 edges after req with inst_o=32'h00500093 and inst_pc_o=0x4.
//  3 Misaligned addr 0x6 -> valid_o=1 with err_o=1, inst_o=32'h00000013.
//    Out-of-range addr 0x400 (DEPTH=256) -> same response.
//  4 Flush in the first BUSY cycle -> no valid_o, stall_o=0 that cycle, IDLE next cycle.
//    A new req at 0x8 is then served normally.
//  5 Load collision: write mem[2]=32'hDEADBEEF on the response edge of a fetch of 0x8
//    holding 32'h00000033 -> inst_o=32'h00000033; a refetch returns 32'hDEADBEEF.
//  6 start_i=0 with req_i=1 -> no accept and stall_o=0.
//    Dropping start_i mid-BUSY still completes the fetch.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch responder.
package fetch_pkg;

  // Responder FSM: waiting for a fetch, or counting down an accepted one.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Word returned on a misaligned or out-of-range fetch (addi x0,x0,0).
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Width of the latency down-counter; supports LATENCY up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/imem_array.sv
// Instruction store: one synchronous write port (load), one read port.
// The read is combinational so the caller samples the old word on the same
// edge that a colliding write lands, giving read-before-write behaviour.
module imem_array #(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Load port: write one word on any enabled edge.
  // NOTE: the array has no reset; its contents survive rst_i and are defined only by loads.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction-memory responder on the PC fetch interface. Accepts a fetch,
// returns the word LATENCY clocks later, stalls the PC while the fetch is
// outstanding, and drops the fetch on a pipeline flush.
module inst_fetch_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] NOP_WORD    = fetch_pkg::NOP_WORD,
  localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             req_i,
  input  logic [31:0]      addr_i,
  input  logic             flush_i,
  input  logic             load_we_i,
  input  logic [IDX_W-1:0] load_addr_i,
  input  logic [31:0]      load_data_i,
  output logic [31:0]      inst_o,
  output logic [31:0]      inst_pc_o,
  output logic             valid_o,
  output logic             err_o,
  output logic             stall_o
);

  import fetch_pkg::*;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q;
  logic [31:0]      rd_data;
  logic [IDX_W-1:0] rd_idx;
  logic             addr_err;
  logic             accept;
  logic             cnt_zero;

  assign rd_idx   = addr_q[IDX_W+1:2];
  // Misaligned byte offset, or any address bit beyond the stored range.
  assign addr_err = (|addr_q[1:0]) | (|addr_q[31:IDX_W+2]);
  assign cnt_zero = (cnt == '0);
  assign accept   = (state == IDLE) & start_i & req_i & ~flush_i;

  // PC holds while a fetch is being accepted or counting down; it is released
  // in the response cycle so the PC advances on the same edge valid_o rises.
  assign stall_o = ~flush_i & (((state == IDLE) & start_i & req_i) |
                               ((state == BUSY) & ~cnt_zero));

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_imem (
    .clk_i (clk_i),
    .we    (load_we_i),
    .waddr (load_addr_i),
    .wdata (load_data_i),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  // Fetch FSM: accept, count down LATENCY edges, then respond or drop on flush.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      inst_o    <= '0;
      inst_pc_o <= '0;
      valid_o   <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= addr_i;
            cnt    <= CNT_W'(LATENCY - 1);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (flush_i) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else begin
            inst_o    <= addr_err ? NOP_WORD : rd_data;
            inst_pc_o <= addr_q;
            valid_o   <= 1'b1;
            err_o     <= addr_err;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
